pipe_sched: RTL and testbench

PIPE_SCHED -- requirements
Module: pipe_sched

---
 rtl/pipe_sched.sv | 149 ++++++++++++++
 tb/tb_pipe_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sched.sv
// Pipeline scheduler: per-register scoreboard, in-flight tracking and halt/drain control.
// Produces the stall, bubble and flush controls for the IF/ID/EX stages.
module pipe_sched #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid_inst,
  input  logic [4:0] id_ra_idx,
  input  logic [4:0] id_rb_idx,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       id_reg_wr,
  input  logic [4:0] id_dest_reg_idx,
  input  logic       id_halt,
  input  logic       ex_take_branch,
  input  logic       mem_busy,
  input  logic       wb_valid,
  input  logic       wb_reg_wr,
  input  logic [4:0] wb_dest_idx,
  output logic       if_stall,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       pipe_stall,
  output logic       halted,
  output logic [1:0] sched_state,
  output logic [1:0] inflight
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_cnt [32];
  logic [1:0]  r_inflight;
  logic [31:0] w_inc;
  logic [31:0] w_dec;
  logic        w_hazard;
  logic        w_issue;
  logic        w_haltEntry;

  // Hazard looks only at registered counts, so a retire in this same cycle cannot clear it.
  assign w_hazard = (id_uses_ra && (id_ra_idx != 5'd0) && (r_cnt[id_ra_idx] != 2'd0)) ||
                    (id_uses_rb && (id_rb_idx != 5'd0) && (r_cnt[id_rb_idx] != 2'd0));

  assign w_issue = id_valid_inst && !id_halt && (r_state == RUN) &&
                   !ex_take_branch && !mem_busy && !w_hazard;

  assign w_haltEntry = (r_state == RUN) && id_valid_inst && id_halt &&
                       !ex_take_branch && !mem_busy;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issue && id_reg_wr && (id_dest_reg_idx != 5'd0)) begin
      w_inc[id_dest_reg_idx] = 1'b1;
    end
    if (wb_valid && wb_reg_wr && (wb_dest_idx != 5'd0)) begin
      w_dec[wb_dest_idx] = 1'b1;
    end
  end

  // Saturating pending counters; register 0 can never be incremented, so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != 2'd3)) begin
          r_cnt[i] <= r_cnt[i] + 2'd1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 2'd0)) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 2'd0;
    end else if (w_issue && !wb_valid && (r_inflight != 2'(MAX_INFLIGHT))) begin
      r_inflight <= r_inflight + 2'd1;
    end else if (!w_issue && wb_valid && (r_inflight != 2'd0)) begin
      r_inflight <= r_inflight - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A branch in DRAIN means the halt was speculative, so fall back to RUN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (w_haltEntry) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (ex_take_branch) begin
          w_nextState = RUN;
        end else if ((r_inflight == 2'd0) && !mem_busy) begin
          w_nextState = HALTED;
        end
      end
      HALTED:  w_nextState = HALTED;
      default: w_nextState = RUN;
    endcase
  end

  always_comb begin
    if_stall     = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_stall   = 1'b0;
    if (!rst) begin
      if (ex_take_branch) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (mem_busy) begin
        pipe_stall = 1'b1;
        if_stall   = 1'b1;
      end else if (r_state != RUN) begin
        if_stall     = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_hazard || w_haltEntry) begin
        if_stall     = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign halted      = (r_state == HALTED) && !rst;
  assign sched_state = r_state;
  assign inflight    = r_inflight;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: a scoreboard model checked against the DUT on every
// falling edge, plus hand-computed expectations at key points of each scenario.
module tb_pipe_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid_inst;
  logic [4:0] id_ra_idx;
  logic [4:0] id_rb_idx;
  logic       id_uses_ra;
  logic       id_uses_rb;
  logic       id_reg_wr;
  logic [4:0] id_dest_reg_idx;
  logic       id_halt;
  logic       ex_take_branch;
  logic       mem_busy;
  logic       wb_valid;
  logic       wb_reg_wr;
  logic [4:0] wb_dest_idx;
  logic       if_stall;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       pipe_stall;
  logic       halted;
  logic [1:0] sched_state;
  logic [1:0] inflight;

  int errCount   = 0;
  int checkCount = 0;
  bit compareEn  = 1'b0;

  // Model state: outstanding writes per register, instructions in flight, 0=RUN 1=DRAIN 2=HALTED.
  int pend [32];
  int mInflight;
  int mState;

  pipe_sched #(.MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid_inst(id_valid_inst), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_reg_wr(id_reg_wr),
    .id_dest_reg_idx(id_dest_reg_idx), .id_halt(id_halt),
    .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_dest_idx(wb_dest_idx),
    .if_stall(if_stall), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .pipe_stall(pipe_stall), .halted(halted), .sched_state(sched_state), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    checkCount++;
    if (got != exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic bit modelHazard();
    bit readsA = id_uses_ra && (id_ra_idx != 5'd0) && (pend[id_ra_idx] > 0);
    bit readsB = id_uses_rb && (id_rb_idx != 5'd0) && (pend[id_rb_idx] > 0);
    return readsA || readsB;
  endfunction

  task automatic modelStep();
    bit issue;
    int nextState;
    issue = id_valid_inst && !id_halt && (mState == 0) && !ex_take_branch &&
            !mem_busy && !modelHazard();
    nextState = mState;
    if (mState == 0 && id_valid_inst && id_halt && !ex_take_branch && !mem_busy) nextState = 1;
    else if (mState == 1 && ex_take_branch) nextState = 0;
    else if (mState == 1 && mInflight == 0 && !mem_busy) nextState = 2;
    if (issue && id_reg_wr && id_dest_reg_idx != 5'd0) pend[id_dest_reg_idx]++;
    if (wb_valid && wb_reg_wr && wb_dest_idx != 5'd0) pend[wb_dest_idx]--;
    if (issue) mInflight++;
    if (wb_valid) mInflight--;
    mState = nextState;
    checkOutput("scoreboard range", (pend[id_dest_reg_idx] inside {[0:3]}) &&
                (pend[wb_dest_idx] inside {[0:3]}) && (mInflight inside {[0:3]}), 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (pend[i]) pend[i] = 0;
      mInflight = 0;
      mState    = 0;
    end else begin
      modelStep();
    end
  end

  // Expected controls follow the priority branch > memory busy > drain/halt > hazard.
  always @(negedge clk) begin
    if (compareEn) begin
      int eStall, eBubble, eFlush, ePipe;
      eStall = 0; eBubble = 0; eFlush = 0; ePipe = 0;
      if (!rst) begin
        if (ex_take_branch) begin
          eFlush = 1; eBubble = 1;
        end else if (mem_busy) begin
          ePipe = 1; eStall = 1;
        end else if (mState != 0 || modelHazard() || (id_valid_inst && id_halt)) begin
          eStall = 1; eBubble = 1;
        end
      end
      checkOutput("cyc if_stall", int'(if_stall), eStall);
      checkOutput("cyc id_ex_bubble", int'(id_ex_bubble), eBubble);
      checkOutput("cyc if_id_flush", int'(if_id_flush), eFlush);
      checkOutput("cyc pipe_stall", int'(pipe_stall), ePipe);
      checkOutput("cyc halted", int'(halted), (!rst && mState == 2) ? 1 : 0);
      checkOutput("cyc sched_state", int'(sched_state), rst ? 0 : mState);
      checkOutput("cyc inflight", int'(inflight), rst ? 0 : mInflight);
    end
  end

  // Index -1 means "not used"; wbDest -1 means no retire, -2 a retire without a register write.
  task automatic applyStimulus(input bit valid, input bit halt, input int ra, input int rb,
                               input int wrDest, input bit branch, input bit busy,
                               input int wbDest);
    id_valid_inst   = valid;
    id_halt         = halt;
    id_uses_ra      = (ra >= 0);
    id_ra_idx       = (ra >= 0) ? 5'(ra) : 5'd7;
    id_uses_rb      = (rb >= 0);
    id_rb_idx       = (rb >= 0) ? 5'(rb) : 5'd9;
    id_reg_wr       = (wrDest >= 0);
    id_dest_reg_idx = (wrDest >= 0) ? 5'(wrDest) : 5'd0;
    ex_take_branch  = branch;
    mem_busy        = busy;
    wb_valid        = (wbDest != -1);
    wb_reg_wr       = (wbDest >= 0);
    wb_dest_idx     = (wbDest >= 0) ? 5'(wbDest) : 5'd0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, -1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, -1, -1, -1, 1, 0, -1);
    compareEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset flush forced low", int'(if_id_flush), 0);
    checkOutput("reset sched_state", int'(sched_state), 0);
    checkOutput("reset inflight", int'(inflight), 0);
    rst = 1'b0;
    idle();
    tick();

    $display("[TB] RAW hazard on x5");
    applyStimulus(1, 0, -1, -1, 5, 0, 0, -1);
    checkOutput("x5 writer issues", int'(if_stall), 0);
    tick();
    checkOutput("inflight after x5 issue", int'(inflight), 1);
    applyStimulus(1, 0, 5, -1, -1, 0, 0, -1);
    checkOutput("x5 reader stalls", int'(if_stall), 1);
    checkOutput("x5 reader bubble", int'(id_ex_bubble), 1);
    tick();
    tick();
    applyStimulus(1, 0, 5, -1, -1, 0, 0, 5);
    checkOutput("x5 stall during retire cycle", int'(if_stall), 1);
    tick();
    applyStimulus(1, 0, 5, -1, -1, 0, 0, -1);
    checkOutput("x5 reader resumes", int'(if_stall), 0);
    checkOutput("inflight before reader issue", int'(inflight), 0);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, -2);
    tick();

    $display("[TB] two writers to x7");
    applyStimulus(1, 0, -1, -1, 7, 0, 0, -1);
    tick();
    tick();
    checkOutput("inflight two x7 writers", int'(inflight), 2);
    applyStimulus(1, 0, -1, 7, -1, 0, 0, 7);
    tick();
    applyStimulus(1, 0, -1, 7, -1, 0, 0, -1);
    checkOutput("x7 still pending after one retire", int'(if_stall), 1);
    tick();
    applyStimulus(1, 0, -1, 7, -1, 0, 0, 7);
    tick();
    applyStimulus(1, 0, -1, 7, -1, 0, 0, -1);
    checkOutput("x7 clear after two retires", int'(if_stall), 0);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, -2);
    tick();

    $display("[TB] x0 is never pending");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, -1);
    checkOutput("x0 first", int'(if_stall), 0);
    tick();
    checkOutput("x0 second", int'(if_stall), 0);
    tick();
    checkOutput("inflight after x0 writes", int'(inflight), 2);
    applyStimulus(0, 0, -1, -1, -1, 0, 0, 0);
    tick();
    tick();

    $display("[TB] control priority");
    applyStimulus(1, 0, -1, -1, 9, 0, 0, -1);
    tick();
    applyStimulus(1, 0, 9, -1, -1, 1, 1, -1);
    checkOutput("prio flush", int'(if_id_flush), 1);
    checkOutput("prio bubble", int'(id_ex_bubble), 1);
    checkOutput("prio pipe_stall", int'(pipe_stall), 0);
    checkOutput("prio if_stall", int'(if_stall), 0);
    tick();
    applyStimulus(1, 0, 9, -1, -1, 0, 1, -1);
    checkOutput("busy pipe_stall", int'(pipe_stall), 1);
    checkOutput("busy bubble", int'(id_ex_bubble), 0);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, 9);
    tick();

    $display("[TB] halt drain");
    applyStimulus(1, 0, -1, -1, 3, 0, 0, -1);
    tick();
    applyStimulus(1, 0, -1, -1, 4, 0, 0, -1);
    tick();
    applyStimulus(1, 1, -1, -1, -1, 0, 0, -1);
    checkOutput("halt entry stall", int'(if_stall), 1);
    checkOutput("halt entry inflight", int'(inflight), 2);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, 3);
    checkOutput("drain state", int'(sched_state), 1);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, 4);
    tick();
    idle();
    checkOutput("drain empty not yet halted", int'(halted), 0);
    tick();
    applyStimulus(1, 0, -1, -1, -1, 0, 0, -1);
    checkOutput("halted flag", int'(halted), 1);
    checkOutput("halted state", int'(sched_state), 2);
    tick();
    checkOutput("halted is sticky", int'(sched_state), 2);
    rst = 1'b1;
    #1;
    checkOutput("reset clears halted", int'(halted), 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    $display("[TB] branch cancels drain");
    applyStimulus(1, 0, -1, -1, 3, 0, 0, -1);
    tick();
    applyStimulus(1, 1, -1, -1, -1, 0, 0, -1);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 1, 0, -1);
    checkOutput("drain branch flush", int'(if_id_flush), 1);
    tick();
    idle();
    checkOutput("back to run", int'(sched_state), 0);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, 3);
    tick();

    $display("[TB] async reset in drain");
    applyStimulus(1, 0, -1, -1, 6, 0, 0, -1);
    tick();
    applyStimulus(1, 0, -1, -1, 8, 0, 0, -1);
    tick();
    applyStimulus(1, 1, -1, -1, -1, 0, 0, -1);
    tick();
    idle();
    checkOutput("pre-reset drain stall", int'(if_stall), 1);
    rst = 1'b1;
    #1;
    checkOutput("async if_stall", int'(if_stall), 0);
    checkOutput("async bubble", int'(id_ex_bubble), 0);
    checkOutput("async sched_state", int'(sched_state), 0);
    checkOutput("async inflight", int'(inflight), 0);
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1, 0, 6, 8, -1, 0, 0, -1);
    checkOutput("counters cleared by reset", int'(if_stall), 0);
    tick();
    applyStimulus(0, 0, -1, -1, -1, 0, 0, -2);
    tick();
    idle();
    tick();

    compareEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
